// File: rtl/down_sram_drain_ctrl.sv
// down_sram_drain_ctrl
//   Drains a row range of the down (output) SRAM of systolic_array_top and
//   serializes each NUM_COL-wide row into OUT_DATA_WIDTH words on a
//   valid/ready stream, column 0 first.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   i_start               start request (only sampled while idle)
//   i_start_addr/i_end_addr  inclusive row range, captured at start; wraps
//   o_busy, o_done        busy from start through the done cycle; done pulse
//   o_down_rd_en/addr     SRAM read port; data returns one cycle later
//   i_down_rd_data        SRAM read data
//   o_data_valid/o_data/o_data_col/o_data_last, i_data_ready  output stream
//
// Build option
//   DOWN_DRAIN_PREFETCH_EN  adds a second row buffer; the next row is read
//   while the current one drains, so rows stream without bubbles.
module down_sram_drain_ctrl #(
  parameter int NUM_COL              = 4,
  parameter int OUT_DATA_WIDTH       = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  localparam int CW    = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int AW    = LOG2_SRAM_BANK_DEPTH,
  localparam int ROW_W = NUM_COL * OUT_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [AW-1:0]             i_start_addr,
  input  logic [AW-1:0]             i_end_addr,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_down_rd_en,
  output logic [AW-1:0]             o_down_rd_addr,
  input  logic [ROW_W-1:0]          i_down_rd_data,
  output logic                      o_data_valid,
  output logic [OUT_DATA_WIDTH-1:0] o_data,
  output logic [CW-1:0]             o_data_col,
  output logic                      o_data_last,
  input  logic                      i_data_ready
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_SEND, S_DONE} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     ptr, end_q;
  logic [CW-1:0]     col;
  logic [ROW_W-1:0]  row_a;
  logic [ROW_W-1:0]  row_cur;
  logic              col_last, at_end, fire;
  logic              pf_issue, pf_ready;

  assign col_last = (col == CW'(NUM_COL - 1));
  assign at_end   = (ptr == end_q);
  assign fire     = (state == S_SEND) && i_data_ready;

`ifdef DOWN_DRAIN_PREFETCH_EN
  logic [ROW_W-1:0] row_b;
  logic             cur;        // which buffer is being drained
  logic             pf_issued;  // next row already requested for this row
  logic             pf_cap;     // prefetched data arrives this cycle

  // Issue before the last column so the data has landed by the time the
  // last word transfers; the alternate buffer is idle until the swap, so a
  // stall can never clobber it.
  assign pf_issue = (state == S_SEND) && !pf_issued && !at_end && !col_last;
  assign pf_ready = pf_issued;
  assign row_cur  = cur ? row_b : row_a;
`else
  assign pf_issue = 1'b0;
  assign pf_ready = 1'b0;
  assign row_cur  = row_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (i_start) state_nx = S_READ;
      S_READ:    state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_SEND;
      S_SEND:
        if (fire && col_last) begin
          if (at_end)        state_nx = S_DONE;
          else if (pf_ready) state_nx = S_SEND;
          else               state_nx = S_READ;
        end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      end_q <= '0;
      col   <= '0;
      row_a <= '0;
`ifdef DOWN_DRAIN_PREFETCH_EN
      row_b     <= '0;
      cur       <= 1'b0;
      pf_issued <= 1'b0;
      pf_cap    <= 1'b0;
`endif
    end else begin
`ifdef DOWN_DRAIN_PREFETCH_EN
      pf_cap <= pf_issue;
      if (pf_issue) pf_issued <= 1'b1;
      if (pf_cap) begin
        if (cur) row_a <= i_down_rd_data;
        else     row_b <= i_down_rd_data;
      end
`endif
      case (state)
        S_IDLE:
          if (i_start) begin
            ptr   <= i_start_addr;
            end_q <= i_end_addr;
            col   <= '0;
`ifdef DOWN_DRAIN_PREFETCH_EN
            cur       <= 1'b0;
            pf_issued <= 1'b0;
`endif
          end
        S_CAPTURE: begin
          col <= '0;
`ifdef DOWN_DRAIN_PREFETCH_EN
          if (cur) row_b <= i_down_rd_data;
          else     row_a <= i_down_rd_data;
`else
          row_a <= i_down_rd_data;
`endif
        end
        S_SEND:
          if (i_data_ready) begin
            if (col_last) begin
              col <= '0;
              if (!at_end) ptr <= ptr + AW'(1);  // natural wrap at 2^AW
`ifdef DOWN_DRAIN_PREFETCH_EN
              if (pf_issued) begin
                cur       <= ~cur;
                pf_issued <= 1'b0;
              end
`endif
            end else begin
              col <= col + CW'(1);
            end
          end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset zeroes them immediately.
  always_comb begin
    o_busy         = (state != S_IDLE);
    o_done         = (state == S_DONE);
    o_data_valid   = (state == S_SEND);
    o_data         = '0;
    o_data_col     = '0;
    o_data_last    = 1'b0;
    o_down_rd_en   = (state == S_READ) || pf_issue;
    o_down_rd_addr = '0;
    if (state == S_READ)  o_down_rd_addr = ptr;
    else if (pf_issue)    o_down_rd_addr = ptr + AW'(1);
    if (state == S_SEND) begin
      o_data      = row_cur[int'(col)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      o_data_col  = col;
      o_data_last = col_last && at_end;
    end
  end

endmodule

// File: tb/tb_down_sram_drain_ctrl.sv
module tb_down_sram_drain_ctrl;
  localparam int NC = 4;
  localparam int W  = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [AW-1:0]   i_start_addr = '0;
  logic [AW-1:0]   i_end_addr = '0;
  logic            o_busy, o_done, o_down_rd_en, o_data_valid, o_data_last;
  logic [AW-1:0]   o_down_rd_addr;
  logic [NC*W-1:0] i_down_rd_data = '0;
  logic [W-1:0]    o_data;
  logic [1:0]      o_data_col;
  logic            i_data_ready = 1'b0;

  down_sram_drain_ctrl #(.NUM_COL(NC), .OUT_DATA_WIDTH(W), .LOG2_SRAM_BANK_DEPTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_end_addr(i_end_addr), .o_busy(o_busy), .o_done(o_done),
    .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
    .i_down_rd_data(i_down_rd_data), .o_data_valid(o_data_valid), .o_data(o_data),
    .o_data_col(o_data_col), .o_data_last(o_data_last), .i_data_ready(i_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   c;
    logic         l;
  } word_t;

  logic [NC*W-1:0] mem [32];
  word_t           exp_q[$];
  logic [AW-1:0]   addr_q[$];
  int              checks = 0;
  int              failures = 0;
  int              hs = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: one-cycle read latency, junk when not reading.
  always @(posedge clk)
    i_down_rd_data <= o_down_rd_en ? mem[o_down_rd_addr]
                                   : {$urandom(), $urandom(), $urandom(), $urandom()};

  // Monitor: address/word scoreboard, stall stability, done placement.
  logic  pv = 1'b0, pr = 1'b0, plx = 1'b0;
  word_t pw = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; plx = 1'b0;
    end else begin
      check("done_after_last", o_done, plx);
      if (pv && !pr) begin
        check("stall_valid", o_data_valid, 1);
        check("stall_word", {o_data, o_data_col, o_data_last}, pw);
      end
      if (o_down_rd_en) begin
        if (addr_q.size() == 0) check("read_expected", 0, o_down_rd_en);
        else check("rd_addr", o_down_rd_addr, addr_q.pop_front());
      end
      if (o_data_valid && i_data_ready) begin
        hs++;
        if (exp_q.size() == 0) check("word_expected", 0, o_data_valid);
        else check("word", {o_data, o_data_col, o_data_last}, exp_q.pop_front());
      end
      plx = o_data_valid && i_data_ready && o_data_last;
      pv  = o_data_valid;
      pr  = i_data_ready;
      pw  = {o_data, o_data_col, o_data_last};
    end
  end

  task automatic push_range(input int s, input int e, output int rows);
    int r;
    r = s;
    rows = 0;
    forever begin
      addr_q.push_back(AW'(r));
      rows++;
      for (int c = 0; c < NC; c++)
        exp_q.push_back({32'(r * 256 + c), 2'(c), (r == e && c == NC - 1)});
      if (r == e) break;
      r = (r + 1) % 32;
    end
  endtask

  task automatic run(input int s, input int e, input bit rnd, input bit inject);
    int rows, n, done_at, exp_done;
    push_range(s, e, rows);
    hs = 0;
    done_at = -1;
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = AW'(s); i_end_addr = AW'(e);
    i_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (n = 1; n < 2000 && done_at < 0; n++) begin
      @(posedge clk); #1;
      i_start = inject && (n == 3);
      if (inject && n == 3) begin i_start_addr = 9; i_end_addr = 9; end
      i_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == 1) check("busy_after_start", o_busy, 1);
      if (o_done) begin
        done_at = n;
        check("busy_in_done", o_busy, 1);
      end
    end
    check("done_seen", done_at >= 0, 1);
    if (!rnd) begin
`ifdef DOWN_DRAIN_PREFETCH_EN
      exp_done = rows * NC + 3;
`else
      exp_done = rows * (NC + 2) + 1;
`endif
      check("done_cycle", done_at, exp_done);
    end
    @(posedge clk); #1;
    check("busy_fall", o_busy, 0);
    check("done_pulse", o_done, 0);
    check("handshakes", hs, rows * NC);
    check("words_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
  endtask

  initial begin
    int rows;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < NC; c++)
        mem[r][c*W +: W] = 32'(r * 256 + c);
    #1;
    check("reset_outputs", {o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_data_valid,
                            o_data, o_data_col, o_data_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(0, 3, 1'b0, 1'b0);   // full-speed four rows
    run(0, 3, 1'b1, 1'b0);   // random backpressure
    run(30, 1, 1'b0, 1'b0);  // wrap through top of address space
    run(5, 5, 1'b0, 1'b0);   // single row
    run(0, 3, 1'b1, 1'b1);   // start pulse while busy is ignored

    // Reset in the middle of a transfer.
    push_range(0, 3, rows);
    hs = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = 0; i_end_addr = 3; i_data_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < 200 && hs < 6; n++) begin
      @(posedge clk); #1;
    end
    check("six_words", hs, 6);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_data_valid,
                                   o_data, o_data_col, o_data_last}, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after_reset", {o_busy, o_done}, 0);
    end

    run(0, 3, 1'b0, 1'b0);   // clean run after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
